// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
//   Constants and helpers shared by the audio output path.
//   FRAME_BITS  : BCK periods per I2S frame (two slots)
//   SLOT_BITS   : BCK periods per channel slot
//   SAMPLE_BITS : width of one PCM sample
//   build_frame : assembles the 64-bit frame word that is shifted out MSB first
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int FRAME_BITS  = 64;
    localparam int SLOT_BITS   = 32;
    localparam int SAMPLE_BITS = 16;
    localparam int BIT_CNT_W   = $clog2(FRAME_BITS);

    typedef logic [SAMPLE_BITS-1:0] sample_t;
    typedef logic [FRAME_BITS-1:0]  frame_t;

    // Each sample sits left-justified in its slot; the unused slot LSBs are zero.
    // Sample bits are passed through verbatim: no scaling or sign extension.
    function automatic frame_t build_frame(input sample_t left, input sample_t right);
        return {left,  {(SLOT_BITS - SAMPLE_BITS){1'b0}},
                right, {(SLOT_BITS - SAMPLE_BITS){1'b0}}};
    endfunction

endpackage

// File: rtl/audio_frame_timer.sv
// -----------------------------------------------------------------------------
// audio_frame_timer
//   Generates I2S frame timing: BCK and LRCK plus a frame-start strobe.
//   Every registered output is computed from the next counter state, so in any
//   cycle the outputs describe the counter state of that same cycle.
// Ports
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   bck          out  bit clock, low for the first BCK_HALF clocks of a period
//   lrck         out  word clock, 0 for bits 0..31, 1 for bits 32..63
//   frame_start  out  high for the single cycle with phase 0 of bit 0
//   bit_tick     out  combinational: the coming clk edge starts a new BCK period
// -----------------------------------------------------------------------------
module audio_frame_timer
    import audio_pkg::*;
#(
    parameter int BCK_HALF = 4
) (
    input  logic clk,
    input  logic rst,
    output logic bck,
    output logic lrck,
    output logic frame_start,
    output logic bit_tick
);

    localparam int PHASE_W = $clog2(2 * BCK_HALF);
    localparam logic [PHASE_W-1:0]   PHASE_LAST = PHASE_W'(2 * BCK_HALF - 1);
    localparam logic [PHASE_W-1:0]   PHASE_HIGH = PHASE_W'(BCK_HALF);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST   = BIT_CNT_W'(FRAME_BITS - 1);

    logic [PHASE_W-1:0]   phase_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [PHASE_W-1:0]   phase_nxt;
    logic [BIT_CNT_W-1:0] bit_nxt;
    // Low for the first cycle after reset: the counters hold at phase 0 / bit 0
    // so that cycle becomes a proper frame start with its strobe.
    logic                 running;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves
        // it unassigned and no latch is inferred.
        phase_nxt = phase_cnt;
        bit_nxt   = bit_cnt;
        if (running) begin
            if (phase_cnt == PHASE_LAST) begin
                phase_nxt = '0;
                bit_nxt   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
            end else begin
                phase_nxt = phase_cnt + 1'b1;
            end
        end
    end

    assign bit_tick = (phase_nxt == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            running     <= 1'b0;
            phase_cnt   <= '0;
            bit_cnt     <= '0;
            bck         <= 1'b0;
            lrck        <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            running     <= 1'b1;
            phase_cnt   <= phase_nxt;
            bit_cnt     <= bit_nxt;
            bck         <= (phase_nxt >= PHASE_HIGH);
            lrck        <= bit_nxt[BIT_CNT_W-1];
            frame_start <= (phase_nxt == '0) && (bit_nxt == '0);
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// -----------------------------------------------------------------------------
// audio_i2s_tx
//   Serialises signed 16-bit left/right samples into a Philips I2S stream and
//   paces the upstream audio sources with a once-per-frame strobe.
//   Frame length is 128*BCK_HALF clk cycles (512 at the default setting).
// Ports
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   left_audio   in   left sample, captured only in the next_sample cycle
//   right_audio  in   right sample, captured only in the next_sample cycle
//   next_sample  out  one-cycle pulse at the start of every frame
//   i2s_lrck     out  word clock: 0 = left slot, 1 = right slot
//   i2s_bck      out  bit clock; the DAC samples data on its rising edge
//   i2s_data     out  serial data, MSB first, changing with BCK falling
// -----------------------------------------------------------------------------
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int BCK_HALF = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] left_audio,
    input  logic [15:0] right_audio,
    output logic        next_sample,
    output logic        i2s_lrck,
    output logic        i2s_bck,
    output logic        i2s_data
);

    logic   frame_start;
    logic   bit_tick;
    frame_t shift_r;
    logic   data_r;

    audio_frame_timer #(
        .BCK_HALF    (BCK_HALF)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .bck         (i2s_bck),
        .lrck        (i2s_lrck),
        .frame_start (frame_start),
        .bit_tick    (bit_tick)
    );

    // The frame word is loaded at the end of the frame-start cycle, then one bit
    // moves to the output at the start of every following BCK period. The output
    // register thus trails the frame by one BCK: bit 0 of a frame carries the
    // last (always zero) bit of the previous word, giving the standard I2S
    // one-bit delay after each LRCK edge. A frame start never coincides with a
    // bit_tick because each BCK period is at least two clk cycles long.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r <= '0;
            data_r  <= 1'b0;
        end else if (frame_start) begin
            shift_r <= build_frame(left_audio, right_audio);
        end else if (bit_tick) begin
            data_r  <= shift_r[FRAME_BITS-1];
            shift_r <= {shift_r[FRAME_BITS-2:0], 1'b0};
        end
    end

    assign next_sample = frame_start;
    assign i2s_data    = data_r;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_audio_i2s_tx
//   Directed bench for audio_i2s_tx with BCK_HALF=4 and BCK_HALF=1 instances.
//   A DAC model records i2s_data at each BCK rising edge and rebuilds the words.
// -----------------------------------------------------------------------------
module tb_audio_i2s_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] left_audio;
    logic [15:0] right_audio;
    logic        sel;

    logic ns4, lr4, bck4, d4;
    logic ns1, lr1, bck1, d1;
    logic ns_s, lr_s, bck_s, d_s;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    audio_i2s_tx #(.BCK_HALF(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .left_audio  (left_audio),
        .right_audio (right_audio),
        .next_sample (ns4),
        .i2s_lrck    (lr4),
        .i2s_bck     (bck4),
        .i2s_data    (d4)
    );

    audio_i2s_tx #(.BCK_HALF(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .left_audio  (left_audio),
        .right_audio (right_audio),
        .next_sample (ns1),
        .i2s_lrck    (lr1),
        .i2s_bck     (bck1),
        .i2s_data    (d1)
    );

    assign ns_s  = sel ? ns1  : ns4;
    assign lr_s  = sel ? lr1  : lr4;
    assign bck_s = sel ? bck1 : bck4;
    assign d_s   = sel ? d1   : d4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Left word: BCK periods 1..16, MSB first.
    function automatic logic [15:0] rx_left(input logic [63:0] rx);
        logic [15:0] w;
        for (int j = 0; j < 16; j++) w[15-j] = rx[1+j];
        return w;
    endfunction

    // Right word: BCK periods 33..48, MSB first.
    function automatic logic [15:0] rx_right(input logic [63:0] rx);
        logic [15:0] w;
        for (int j = 0; j < 16; j++) w[15-j] = rx[33+j];
        return w;
    endfunction

    // Periods that must carry zero: 0, 17..32, 49..63.
    function automatic logic [63:0] zero_mask();
        logic [63:0] m;
        for (int k = 0; k < 64; k++) m[k] = (k == 0) || (k >= 17 && k <= 32) || (k >= 49);
        return m;
    endfunction

    // Step to the next pulse of next_sample; n = clk cycles taken (bounded).
    task automatic wait_ns(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ns_s !== 1'b1 && n < 4000);
    endtask

    // Called at the negedge of a frame-start cycle. Walks one whole frame,
    // checking bck/lrck/next_sample shape and data/lrck stability outside BCK
    // falling edges, records data at each BCK rise into rx[k], and drives l1/r1
    // onto the inputs one cycle after frame start. Ends on the next frame start.
    task automatic capture_frame(input int h, input logic [15:0] l1, input logic [15:0] r1,
                                 output logic [63:0] rx, output int terr, output logic ns_end);
        logic pd, plr;
        int   ph, k;
        rx   = '0;
        terr = 0;
        pd   = 1'b0;
        plr  = 1'b0;
        for (int c = 0; c < 128 * h; c++) begin
            if (c > 0) @(negedge clk);
            ph = c % (2 * h);
            k  = c / (2 * h);
            if (bck_s !== (ph >= h)) terr++;
            if (ns_s  !== (c == 0))  terr++;
            if (lr_s  !== (k >= 32)) terr++;
            if (c > 0 && ph != 0 && (d_s !== pd || lr_s !== plr)) terr++;
            if (ph == h) rx[k] = d_s;
            pd  = d_s;
            plr = lr_s;
            if (c == 1) begin
                left_audio  = l1;
                right_audio = r1;
            end
        end
        @(negedge clk);
        ns_end = ns_s;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [63:0] rx;
        int          terr;
        int          n;
        logic        ns_end;

        sel         = 1'b0;
        rst         = 1'b1;
        left_audio  = 16'h8001;
        right_audio = 16'h7FFE;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ns",   {31'd0, ns_s},  32'd0);
        check("rst_bck",  {31'd0, bck_s}, 32'd0);
        check("rst_lrck", {31'd0, lr_s},  32'd0);
        check("rst_data", {31'd0, d_s},   32'd0);

        // Release: strobe in cycle 1, then a 512-cycle period for 10 frames
        rst = 1'b0;
        @(negedge clk);
        check("first_ns",   {31'd0, ns_s},  32'd1);
        check("first_bck",  {31'd0, bck_s}, 32'd0);
        check("first_lrck", {31'd0, lr_s},  32'd0);
        check("first_data", {31'd0, d_s},   32'd0);
        for (int f = 0; f < 10; f++) begin
            wait_ns(n);
            check($sformatf("period_%0d", f), 32'(n), 32'd512);
        end

        // Serialise 8001/7FFE with full timing checks
        capture_frame(4, 16'h8001, 16'h7FFE, rx, terr, ns_end);
        check("l_8001",  {16'd0, rx_left(rx)},  32'h8001);
        check("r_7ffe",  {16'd0, rx_right(rx)}, 32'h7FFE);
        check("zero_slot_lo", rx[31:0]  & zero_mask_lo(), 32'd0);
        check("zero_slot_hi", rx[63:32] & zero_mask_hi(), 32'd0);
        check("timing_h4", 32'(terr), 32'd0);
        check("ns_end_h4", {31'd0, ns_end}, 32'd1);

        // Capture window: only values present in the strobe cycle are taken
        left_audio  = 16'h1234;
        right_audio = 16'h5678;
        capture_frame(4, 16'hDEAD, 16'hBFEF, rx, terr, ns_end);
        check("win_l_old", {16'd0, rx_left(rx)},  32'h1234);
        check("win_r_old", {16'd0, rx_right(rx)}, 32'h5678);
        check("win_timing", 32'(terr), 32'd0);
        capture_frame(4, 16'hDEAD, 16'hBFEF, rx, terr, ns_end);
        check("win_l_new", {16'd0, rx_left(rx)},  32'hDEAD);
        check("win_r_new", {16'd0, rx_right(rx)}, 32'hBFEF);

        // Mid-frame reset at bit 40 (right slot, carrying R[8]=1)
        repeat (320) @(negedge clk);
        check("mid_lrck", {31'd0, lr_s},  32'd1);
        check("mid_data", {31'd0, d_s},   32'd1);
        check("mid_bck",  {31'd0, bck_s}, 32'd0);
        rst         = 1'b1;
        left_audio  = 16'hCAFE;
        right_audio = 16'h1111;
        @(negedge clk);
        check("abort_ns",   {31'd0, ns_s},  32'd0);
        check("abort_lrck", {31'd0, lr_s},  32'd0);
        check("abort_data", {31'd0, d_s},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        capture_frame(4, 16'hCAFE, 16'h1111, rx, terr, ns_end);
        check("restart_l", {16'd0, rx_left(rx)},  32'hCAFE);
        check("restart_r", {16'd0, rx_right(rx)}, 32'h1111);
        check("restart_timing", 32'(terr), 32'd0);

        // BCK_HALF = 1 instance
        sel         = 1'b1;
        rst         = 1'b1;
        left_audio  = 16'hA5A5;
        right_audio = 16'h5A5A;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        capture_frame(1, 16'hA5A5, 16'h5A5A, rx, terr, ns_end);
        check("h1_l", {16'd0, rx_left(rx)},  32'hA5A5);
        check("h1_r", {16'd0, rx_right(rx)}, 32'h5A5A);
        check("h1_zero_lo", rx[31:0]  & zero_mask_lo(), 32'd0);
        check("h1_zero_hi", rx[63:32] & zero_mask_hi(), 32'd0);
        check("h1_timing", 32'(terr), 32'd0);
        check("h1_period", {31'd0, ns_end}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    function automatic logic [31:0] zero_mask_lo();
        logic [63:0] m;
        m = zero_mask();
        return m[31:0];
    endfunction

    function automatic logic [31:0] zero_mask_hi();
        logic [63:0] m;
        m = zero_mask();
        return m[63:32];
    endfunction

endmodule
